// File: rtl/mips_regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the MIPS register file with pending scoreboard.
// The core side uses master; the register file uses slave.
interface mips_regfile_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] read_reg;
  logic [NUM_READ*DATA_W-1:0] read_data;
  logic [NUM_READ-1:0]        read_ready;
  logic                       write_en;
  logic [ADDR_W-1:0]          write_reg;
  logic [DATA_W-1:0]          write_data;
  logic                       alloc_en;
  logic [ADDR_W-1:0]          alloc_reg;
  logic                       pending_any;

  modport master (
    output read_reg, write_en, write_reg, write_data, alloc_en, alloc_reg,
    input  read_data, read_ready, pending_any
  );

  modport slave (
    input  read_reg, write_en, write_reg, write_data, alloc_en, alloc_reg,
    output read_data, read_ready, pending_any
  );
endinterface

// File: rtl/mips_regfile_scoreboard.sv
// MIPS GPR file: NUM_READ combinational read ports with write-through bypass,
// one write port, and a per-register pending scoreboard. r0 is hardwired to zero.
module mips_regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) (
  input  logic clk,
  input  logic reset,
  mips_regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]           pend;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]        rd_ready;
  logic [ADDR_W-1:0]          ra;
  logic                       hit;

  // Commit stage: register write and scoreboard update share the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      pend <= '0;
    end else begin
      if (bus.write_en && bus.write_reg != '0)
        regs[bus.write_reg] <= bus.write_data;
      if (bus.write_en)
        pend[bus.write_reg] <= 1'b0;
      // Issued after the clear so a newer producer keeps the bit set.
      if (bus.alloc_en && bus.alloc_reg != '0)
        pend[bus.alloc_reg] <= 1'b1;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    ra       = '0;
    hit      = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra  = bus.read_reg[i*ADDR_W +: ADDR_W];
      hit = bus.write_en && (bus.write_reg == ra);
      if (ra == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_ready[i]                 = 1'b1;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = hit ? bus.write_data : regs[ra];
        rd_ready[i]                 = !pend[ra] || hit;
      end
    end
  end

  assign bus.read_data   = rd_data;
  assign bus.read_ready  = rd_ready;
  assign bus.pending_any = |pend;
endmodule

// File: tb/tb_mips_regfile_scoreboard.sv
// Directed bench for mips_regfile_scoreboard: reset, write/read, r0, bypass,
// scoreboard alloc/clear, alloc-wins collision and asynchronous mid-cycle reset.
module tb_mips_regfile_scoreboard;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_READ = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) bus ();

  mips_regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NUM_READ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_read(input logic [ADDR_W-1:0] p1, input logic [ADDR_W-1:0] p0);
    bus.read_reg = {p1, p0};
  endtask

  task automatic idle_ctrl();
    bus.write_en   = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_reg  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_ctrl();
    set_read(5'd0, 5'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state on every register, both ports
    for (int r = 0; r < 32; r++) begin
      set_read(r[4:0], r[4:0]);
      #1;
      chk("rst_data", {32'b0, bus.read_data}, 64'h0);
      chk("rst_ready", {62'b0, bus.read_ready}, 64'h3);
      chk("rst_pend", {63'b0, bus.pending_any}, 64'h0);
    end

    // 2: write r5, read it back on both ports
    @(negedge clk);
    bus.write_en = 1'b1; bus.write_reg = 5'd5; bus.write_data = 32'hDEADBEEF;
    set_read(5'd0, 5'd0);
    @(negedge clk);
    idle_ctrl();
    set_read(5'd5, 5'd5);
    #1;
    chk("r5_both", {32'b0, bus.read_data}, 64'hDEADBEEF_DEADBEEF);
    chk("r5_ready", {62'b0, bus.read_ready}, 64'h3);

    // 3: write to r0 is ignored, including the bypass path
    @(negedge clk);
    bus.write_en = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'hFFFFFFFF;
    set_read(5'd0, 5'd0);
    #1;
    chk("r0_bypass", {32'b0, bus.read_data}, 64'h0);
    @(negedge clk);
    idle_ctrl();
    #1;
    chk("r0_after", {32'b0, bus.read_data}, 64'h0);
    chk("r0_pend", {63'b0, bus.pending_any}, 64'h0);

    // 4: same-cycle bypass on port 1, port 0 independent
    @(negedge clk);
    bus.write_en = 1'b1; bus.write_reg = 5'd7; bus.write_data = 32'h00001234;
    set_read(5'd7, 5'd5);
    #1;
    chk("byp_p1", {32'b0, bus.read_data[63:32]}, 64'h1234);
    chk("byp_p0", {32'b0, bus.read_data[31:0]}, 64'hDEADBEEF);
    @(negedge clk);
    idle_ctrl();
    #1;
    chk("r7_stored", {32'b0, bus.read_data[63:32]}, 64'h1234);

    // 5: alloc r9, ready drops next cycle, write clears it with bypass
    @(negedge clk);
    bus.alloc_en = 1'b1; bus.alloc_reg = 5'd9;
    set_read(5'd9, 5'd9);
    #1;
    chk("alloc_same_ready", {62'b0, bus.read_ready}, 64'h3);
    chk("alloc_same_pend", {63'b0, bus.pending_any}, 64'h0);
    @(negedge clk);
    idle_ctrl();
    #1;
    chk("r9_not_ready", {62'b0, bus.read_ready}, 64'h0);
    chk("r9_pend", {63'b0, bus.pending_any}, 64'h1);
    @(negedge clk);
    bus.write_en = 1'b1; bus.write_reg = 5'd9; bus.write_data = 32'h00000055;
    #1;
    chk("r9_wb_ready", {62'b0, bus.read_ready}, 64'h3);
    chk("r9_wb_data", {32'b0, bus.read_data}, 64'h00000055_00000055);
    chk("r9_wb_pend", {63'b0, bus.pending_any}, 64'h1);
    @(negedge clk);
    idle_ctrl();
    #1;
    chk("r9_clear_ready", {62'b0, bus.read_ready}, 64'h3);
    chk("r9_clear_pend", {63'b0, bus.pending_any}, 64'h0);
    chk("r9_data", {32'b0, bus.read_data}, 64'h00000055_00000055);

    // 6: alloc and write r3 together -> alloc wins
    @(negedge clk);
    bus.alloc_en = 1'b1; bus.alloc_reg = 5'd3;
    bus.write_en = 1'b1; bus.write_reg = 5'd3; bus.write_data = 32'h000000AA;
    set_read(5'd3, 5'd3);
    #1;
    chk("r3_byp_ready", {62'b0, bus.read_ready}, 64'h3);
    @(negedge clk);
    idle_ctrl();
    #1;
    chk("r3_pend_kept", {62'b0, bus.read_ready}, 64'h0);
    chk("r3_pend_any", {63'b0, bus.pending_any}, 64'h1);
    chk("r3_data", {32'b0, bus.read_data}, 64'h000000AA_000000AA);

    // asynchronous reset between clock edges
    #1;
    reset = 1'b1;
    #1;
    chk("arst_ready", {62'b0, bus.read_ready}, 64'h3);
    chk("arst_pend", {63'b0, bus.pending_any}, 64'h0);
    chk("arst_r3", {32'b0, bus.read_data}, 64'h0);
    set_read(5'd7, 5'd5);
    #1;
    chk("arst_r7_r5", {32'b0, bus.read_data}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_data", {32'b0, bus.read_data}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
